encode_loader: RTL and testbench

- Inverse of the instruction decoder: accepts decoded instruction fields over a valid/ready stream and packs them into RV32I 32-bit words.
- Writes the packed words sequentially into instruction memory through a granted write port.
- Boot/test program loader in front of imem. Supports exactly the formats the decoder supports: R (0110011), LOAD (0000011), OP-IMM (0010011), STORE (0100011), LUI (0110111).

---
 rtl/encode_loader_pkg.sv | 28 ++
 rtl/encode_loader_if.sv | 40 ++++
 rtl/encode_loader_pack.sv | 42 ++++
 rtl/encode_loader.sv | 124 ++++++++++++
 tb/tb_encode_loader.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/encode_loader_pkg.sv
// Shared definitions for the RV32I program loader: opcodes, loader states
// and the decoded-field bundle that the decoder produces and the loader consumes.
package encode_loader_pkg;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } load_state_t;

  typedef struct packed {
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  funct7;
    logic [31:0] imm;
  } instr_fields_t;

endpackage

// File: rtl/encode_loader_if.sv
// Bundle of the loader's control, field stream, imem write port and status.
// slave = loader side, master = the agent feeding fields and owning imem.
interface encode_loader_if #(parameter int ADDR_WIDTH = 8);

  logic                  start;
  logic                  in_valid;
  logic                  in_ready;
  logic [6:0]            in_opcode;
  logic [4:0]            in_rd;
  logic [2:0]            in_funct3;
  logic [4:0]            in_rs1;
  logic [4:0]            in_rs2;
  logic [6:0]            in_funct7;
  logic [31:0]           in_imm;
  logic                  in_last;
  logic                  imem_we;
  logic                  imem_gnt;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [31:0]           imem_wdata;
  logic                  busy;
  logic                  done;
  logic                  full;
  logic                  err_opcode;
  logic [ADDR_WIDTH:0]   count;

  modport slave (
    input  start, in_valid, in_opcode, in_rd, in_funct3, in_rs1, in_rs2,
           in_funct7, in_imm, in_last, imem_gnt,
    output in_ready, imem_we, imem_addr, imem_wdata, busy, done, full,
           err_opcode, count
  );

  modport master (
    output start, in_valid, in_opcode, in_rd, in_funct3, in_rs1, in_rs2,
           in_funct7, in_imm, in_last, imem_gnt,
    input  in_ready, imem_we, imem_addr, imem_wdata, busy, done, full,
           err_opcode, count
  );

endinterface

// File: rtl/encode_loader_pack.sv
// Combinational packer: decoded fields -> RV32I instruction word, plus a flag
// saying whether the opcode is one of the formats the decoder understands.
module encode_pack
  import encode_loader_pkg::*;
(
  input  instr_fields_t i_fields,
  output logic [31:0]   o_word,
  output logic          o_supported
);

  // Select the bit layout by opcode; unused fields and excess imm bits drop out.
  always_comb begin
    o_word      = '0;
    o_supported = 1'b0;
    case (i_fields.opcode)
      OP_R: begin
        o_word      = {i_fields.funct7, i_fields.rs2, i_fields.rs1,
                       i_fields.funct3, i_fields.rd, i_fields.opcode};
        o_supported = 1'b1;
      end
      OP_LOAD, OP_IMM: begin
        o_word      = {i_fields.imm[11:0], i_fields.rs1,
                       i_fields.funct3, i_fields.rd, i_fields.opcode};
        o_supported = 1'b1;
      end
      OP_STORE: begin
        o_word      = {i_fields.imm[11:5], i_fields.rs2, i_fields.rs1,
                       i_fields.funct3, i_fields.imm[4:0], i_fields.opcode};
        o_supported = 1'b1;
      end
      OP_LUI: begin
        o_word      = {i_fields.imm[31:12], i_fields.rd, i_fields.opcode};
        o_supported = 1'b1;
      end
      default: begin
        o_word      = '0;
        o_supported = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/encode_loader.sv
// Program loader: accepts decoded instruction fields, packs them into RV32I
// words and writes them sequentially into imem from address 0.
module encode_loader
  import encode_loader_pkg::*;
#(
  parameter int INSTR_WIDTH = 32,
  parameter int ADDR_WIDTH  = 8
) (
  input  logic            clk,
  input  logic            rst,
  encode_loader_if.slave  bus
);

  localparam logic [ADDR_WIDTH:0]   CAP      = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH-1:0] MAX_ADDR = {ADDR_WIDTH{1'b1}};
  localparam logic [ADDR_WIDTH:0]   ONE_CNT  = (ADDR_WIDTH+1)'(1);

  load_state_t             r_state;
  logic                    r_pend_valid;
  logic [31:0]             r_pend_word;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [ADDR_WIDTH:0]     r_count;
  logic                    r_full;
  logic                    r_err;
  logic                    r_saw_last;

  instr_fields_t           w_fields;
  logic [31:0]             w_word;
  logic                    w_sup;
  logic [ADDR_WIDTH:0]     w_committed;
  logic [ADDR_WIDTH:0]     w_count_nxt;
  logic                    w_space;
  logic                    w_ready;
  logic                    w_accept;
  logic                    w_grant;
  logic                    w_fill;

  assign w_fields = '{opcode: bus.in_opcode, rd: bus.in_rd, funct3: bus.in_funct3,
                      rs1: bus.in_rs1, rs2: bus.in_rs2, funct7: bus.in_funct7,
                      imm: bus.in_imm};

  encode_pack u_pack (
    .i_fields    (w_fields),
    .o_word      (w_word),
    .o_supported (w_sup)
  );

  // Words granted plus the one still waiting for grant; a grant this cycle
  // only moves a word from pending to counted, so the sum is unaffected.
  assign w_committed = r_count + {{ADDR_WIDTH{1'b0}}, r_pend_valid};
  assign w_count_nxt = r_count + {{ADDR_WIDTH{1'b0}}, w_grant};
  assign w_space     = (w_committed < CAP);
  assign w_grant     = r_pend_valid && bus.imem_gnt;
  assign w_ready     = (r_state == ST_LOAD) && (!r_pend_valid || bus.imem_gnt) && w_space;
  assign w_accept    = bus.in_valid && w_ready;
  assign w_fill      = w_accept && w_sup && ((w_committed + ONE_CNT) == CAP);

  // Session FSM with the pending-word register, address and count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_pend_valid <= 1'b0;
      r_pend_word  <= '0;
      r_addr       <= '0;
      r_count      <= '0;
      r_full       <= 1'b0;
      r_err        <= 1'b0;
      r_saw_last   <= 1'b0;
    end else begin
      if (w_grant) begin
        r_count <= w_count_nxt;
        if (r_addr != MAX_ADDR) r_addr <= r_addr + ADDR_WIDTH'(1);
      end

      if (w_accept && w_sup) begin
        r_pend_valid <= 1'b1;
        r_pend_word  <= w_word;
      end else if (w_grant) begin
        r_pend_valid <= 1'b0;
      end

      case (r_state)
        ST_IDLE: begin
          if (bus.start) r_state <= ST_LOAD;
        end
        ST_LOAD: begin
          if (w_accept) begin
            if (!w_sup)      r_err      <= 1'b1;
            if (bus.in_last) r_saw_last <= 1'b1;
            if (bus.in_last || w_fill) r_state <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          if (!r_pend_valid || w_grant) begin
            r_state <= ST_DONE;
            r_full  <= (w_count_nxt == CAP) && !r_saw_last;
          end
        end
        ST_DONE: begin
          if (bus.start) begin
            r_state    <= ST_LOAD;
            r_count    <= '0;
            r_addr     <= '0;
            r_full     <= 1'b0;
            r_err      <= 1'b0;
            r_saw_last <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready   = w_ready;
  assign bus.imem_we    = r_pend_valid;
  assign bus.imem_addr  = r_addr;
  assign bus.imem_wdata = r_pend_word;
  assign bus.busy       = (r_state == ST_LOAD) || (r_state == ST_FLUSH);
  assign bus.done       = (r_state == ST_DONE);
  assign bus.full       = r_full;
  assign bus.err_opcode = r_err;
  assign bus.count      = r_count;

endmodule

// File: tb/tb_encode_loader.sv
// Directed bench for encode_loader: one 8-bit-address instance for the main
// sequences and one 2-bit-address instance for the capacity boundary.
module tb_encode_loader;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;
  int   offered;
  int   nwr;
  logic acc;

  always #5 clk = ~clk;

  encode_loader_if #(.ADDR_WIDTH(8)) bus ();
  encode_loader_if #(.ADDR_WIDTH(2)) bus2 ();

  encode_loader #(.INSTR_WIDTH(32), .ADDR_WIDTH(8)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  encode_loader #(.INSTR_WIDTH(32), .ADDR_WIDTH(2)) u_dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [6:0] op, input logic [4:0] rd, input logic [2:0] f3,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [6:0] f7,
                       input logic [31:0] imm, input logic last);
    bus.in_valid  = 1'b1;
    bus.in_opcode = op;
    bus.in_rd     = rd;
    bus.in_funct3 = f3;
    bus.in_rs1    = rs1;
    bus.in_rs2    = rs2;
    bus.in_funct7 = f7;
    bus.in_imm    = imm;
    bus.in_last   = last;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic drive2(input int k);
    bus2.in_valid  = 1'b1;
    bus2.in_opcode = 7'b0010011;
    bus2.in_rd     = 5'(k);
    bus2.in_funct3 = 3'd0;
    bus2.in_rs1    = 5'd0;
    bus2.in_rs2    = 5'd0;
    bus2.in_funct7 = 7'd0;
    bus2.in_imm    = 32'(k);
    bus2.in_last   = 1'b0;
  endtask

  function automatic logic [31:0] exp_addi(input int k);
    return {12'(k), 5'd0, 3'd0, 5'(k), 7'h13};
  endfunction

  task automatic new_session();
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  initial begin
    bus.start = 1'b0;  bus.imem_gnt = 1'b0;
    bus2.start = 1'b0; bus2.imem_gnt = 1'b0;
    idle();
    bus.in_opcode = '0; bus.in_rd = '0; bus.in_funct3 = '0; bus.in_rs1 = '0;
    bus.in_rs2 = '0; bus.in_funct7 = '0; bus.in_imm = '0;
    drive2(0);
    bus2.in_valid = 1'b0;

    // reset state
    step(); step();
    rst = 1'b0;
    step();
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_we",       32'(bus.imem_we), 32'd0);
    chk("rst_addr",     32'(bus.imem_addr), 32'd0);
    chk("rst_wdata",    bus.imem_wdata, 32'd0);
    chk("rst_busy",     32'(bus.busy), 32'd0);
    chk("rst_done",     32'(bus.done), 32'd0);
    chk("rst_full",     32'(bus.full), 32'd0);
    chk("rst_err",      32'(bus.err_opcode), 32'd0);
    chk("rst_count",    32'(bus.count), 32'd0);
    chk("rst2_busy",    32'(bus2.busy), 32'd0);

    // ADD x3,x1,x2
    bus.start = 1'b1; step(); bus.start = 1'b0;
    chk("t1_busy",  32'(bus.busy), 32'd1);
    chk("t1_ready", 32'(bus.in_ready), 32'd1);
    drive(7'b0110011, 5'd3, 3'd0, 5'd1, 5'd2, 7'd0, 32'd0, 1'b0);
    step();
    idle();
    chk("t1_we",    32'(bus.imem_we), 32'd1);
    chk("t1_addr",  32'(bus.imem_addr), 32'd0);
    chk("t1_wdata", bus.imem_wdata, 32'h002081B3);
    chk("t1_ready_hold", 32'(bus.in_ready), 32'd0);
    bus.imem_gnt = 1'b1;
    step();
    bus.imem_gnt = 1'b0;
    chk("t1_we_after", 32'(bus.imem_we), 32'd0);
    chk("t1_count",    32'(bus.count), 32'd1);
    chk("t1_addr_inc", 32'(bus.imem_addr), 32'd1);

    // ADDI x5,x0,-1 then LW x4,-4(x2) back-to-back
    new_session();
    bus.imem_gnt = 1'b1;
    drive(7'b0010011, 5'd5, 3'd0, 5'd0, 5'd0, 7'd0, 32'hFFFFFFFF, 1'b0);
    step();
    chk("t2_addi_we",    32'(bus.imem_we), 32'd1);
    chk("t2_addi_addr",  32'(bus.imem_addr), 32'd0);
    chk("t2_addi_wdata", bus.imem_wdata, 32'hFFF00293);
    chk("t2_ready_b2b",  32'(bus.in_ready), 32'd1);
    drive(7'b0000011, 5'd4, 3'b010, 5'd2, 5'd0, 7'd0, 32'hFFFFFFFC, 1'b0);
    step();
    idle();
    chk("t2_lw_we",    32'(bus.imem_we), 32'd1);
    chk("t2_lw_addr",  32'(bus.imem_addr), 32'd1);
    chk("t2_lw_wdata", bus.imem_wdata, 32'hFFC12203);
    step();
    bus.imem_gnt = 1'b0;
    chk("t2_count", 32'(bus.count), 32'd2);
    chk("t2_we_end", 32'(bus.imem_we), 32'd0);

    // SW x2,8(x1) stalled three cycles, then LUI with in_last
    new_session();
    drive(7'b0100011, 5'd0, 3'b010, 5'd1, 5'd2, 7'd0, 32'd8, 1'b0);
    step();
    drive(7'b0110111, 5'd7, 3'd0, 5'd0, 5'd0, 7'd0, 32'h12345000, 1'b1);
    for (int c = 0; c < 3; c++) begin
      chk("t3_sw_we",    32'(bus.imem_we), 32'd1);
      chk("t3_sw_addr",  32'(bus.imem_addr), 32'd0);
      chk("t3_sw_wdata", bus.imem_wdata, 32'h0020A423);
      chk("t3_ready",    32'(bus.in_ready), 32'd0);
      step();
    end
    bus.imem_gnt = 1'b1;
    step();
    idle();
    chk("t3_lui_we",    32'(bus.imem_we), 32'd1);
    chk("t3_lui_addr",  32'(bus.imem_addr), 32'd1);
    chk("t3_lui_wdata", bus.imem_wdata, 32'h123453B7);
    chk("t3_flush_busy", 32'(bus.busy), 32'd1);
    step();
    bus.imem_gnt = 1'b0;
    chk("t3_done",  32'(bus.done), 32'd1);
    chk("t3_busy",  32'(bus.busy), 32'd0);
    chk("t3_count", 32'(bus.count), 32'd2);
    chk("t3_full",  32'(bus.full), 32'd0);
    chk("t3_we",    32'(bus.imem_we), 32'd0);
    bus.start = 1'b1; step(); bus.start = 1'b0;
    chk("t3_restart_done",  32'(bus.done), 32'd0);
    chk("t3_restart_busy",  32'(bus.busy), 32'd1);
    chk("t3_restart_count", 32'(bus.count), 32'd0);
    chk("t3_restart_addr",  32'(bus.imem_addr), 32'd0);

    // unsupported opcode between two valid bundles
    new_session();
    chk("t4_err_clear", 32'(bus.err_opcode), 32'd0);
    bus.imem_gnt = 1'b1;
    drive(7'b0110011, 5'd3, 3'd0, 5'd1, 5'd2, 7'd0, 32'd0, 1'b0);
    step();
    chk("t4_w0_addr",  32'(bus.imem_addr), 32'd0);
    chk("t4_w0_wdata", bus.imem_wdata, 32'h002081B3);
    drive(7'b1101111, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd0, 1'b0);
    step();
    chk("t4_err",   32'(bus.err_opcode), 32'd1);
    chk("t4_no_we", 32'(bus.imem_we), 32'd0);
    chk("t4_count_hold", 32'(bus.count), 32'd1);
    drive(7'b0010011, 5'd5, 3'd0, 5'd0, 5'd0, 7'd0, 32'hFFFFFFFF, 1'b0);
    step();
    idle();
    chk("t4_w1_we",    32'(bus.imem_we), 32'd1);
    chk("t4_w1_addr",  32'(bus.imem_addr), 32'd1);
    chk("t4_w1_wdata", bus.imem_wdata, 32'hFFF00293);
    step();
    bus.imem_gnt = 1'b0;
    chk("t4_count", 32'(bus.count), 32'd2);
    chk("t4_addr",  32'(bus.imem_addr), 32'd2);

    // capacity boundary on the 4-word instance
    bus2.start = 1'b1; step(); bus2.start = 1'b0;
    bus2.imem_gnt = 1'b1;
    offered = 0;
    nwr = 0;
    drive2(0);
    for (int c = 0; c < 12; c++) begin
      acc = bus2.in_valid && bus2.in_ready;
      if (bus2.imem_we && bus2.imem_gnt) begin
        chk("t5_addr",  32'(bus2.imem_addr), 32'(nwr));
        chk("t5_wdata", bus2.imem_wdata, exp_addi(nwr));
        nwr++;
      end
      step();
      if (acc) begin
        offered++;
        if (offered < 6) drive2(offered);
        else bus2.in_valid = 1'b0;
      end
    end
    chk("t5_writes",   32'(nwr), 32'd4);
    chk("t5_accepted", 32'(offered), 32'd4);
    chk("t5_full",     32'(bus2.full), 32'd1);
    chk("t5_done",     32'(bus2.done), 32'd1);
    chk("t5_ready",    32'(bus2.in_ready), 32'd0);
    chk("t5_count",    32'(bus2.count), 32'd4);
    chk("t5_addr_sat", 32'(bus2.imem_addr), 32'd3);
    bus2.in_valid = 1'b0;
    bus2.imem_gnt = 1'b0;

    // reset while a write is waiting for grant
    new_session();
    drive(7'b0110011, 5'd3, 3'd0, 5'd1, 5'd2, 7'd0, 32'd0, 1'b0);
    step();
    idle();
    chk("t6_we_pending", 32'(bus.imem_we), 32'd1);
    rst = 1'b1;
    step();
    chk("t6_we",    32'(bus.imem_we), 32'd0);
    chk("t6_addr",  32'(bus.imem_addr), 32'd0);
    chk("t6_wdata", bus.imem_wdata, 32'd0);
    chk("t6_busy",  32'(bus.busy), 32'd0);
    chk("t6_done",  32'(bus.done), 32'd0);
    chk("t6_count", 32'(bus.count), 32'd0);
    chk("t6_ready", 32'(bus.in_ready), 32'd0);
    rst = 1'b0;
    bus.start = 1'b1; step(); bus.start = 1'b0;
    bus.imem_gnt = 1'b1;
    drive(7'b0110111, 5'd7, 3'd0, 5'd0, 5'd0, 7'd0, 32'h12345000, 1'b1);
    step();
    idle();
    chk("t6_reload_addr",  32'(bus.imem_addr), 32'd0);
    chk("t6_reload_wdata", bus.imem_wdata, 32'h123453B7);
    step();
    bus.imem_gnt = 1'b0;
    chk("t6_reload_done",  32'(bus.done), 32'd1);
    chk("t6_reload_count", 32'(bus.count), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
